// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake on both sides, status flags and a
// multi-cycle shift-add multiplier; one operation in flight at a time.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_MUL = 4'd9
    } op_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [SHW-1:0]     count;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_ill;
    logic [WIDTH:0]     wide;
    logic [SHW-1:0]     shamt;

    logic accept;
    logic mul_last;

    assign accept   = in_valid && in_ready;
    assign mul_last = (count == SHW'(WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero      = (result == '0);
    assign negative  = result[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = (opcode == OP_MUL) ? MUL : DONE;
            MUL:  if (mul_last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        wide      = '0;
        shamt     = b[SHW-1:0];
        case (opcode)
            OP_ADD: begin
                wide      = {1'b0, a} + {1'b0, b};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the zero-extended difference is the unsigned borrow.
                wide      = {1'b0, a} - {1'b0, b};
                alu_res   = wide[WIDTH-1:0];
                alu_carry = wide[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOT: alu_res = ~a;
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SRA: alu_res = WIDTH'($signed(a) >>> shamt);
            OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        acc_next = acc;
        if (mplier[0]) acc_next = acc + ({{WIDTH{1'b0}}, mcand} << count);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (opcode == OP_MUL) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end else begin
                        result   <= alu_res;
                        carry    <= alu_carry;
                        overflow <= alu_ovf;
                        illegal  <= alu_ill;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // Final iteration folds into the result write so DONE follows immediately.
                    if (mul_last) begin
                        result   <= acc_next[WIDTH-1:0];
                        carry    <= |acc_next[2*WIDTH-1:WIDTH];
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq with hand-computed expectations.
module tb_alu_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             negative;
    logic             overflow;
    logic             illegal;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry),
        .negative(negative), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request; leaves the bench #1 after the accept edge.
    task automatic issue(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic [3:0] op);
        @(negedge clk);
        a        = va;
        b        = vb;
        opcode   = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag,
                          input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic [3:0] op,
                          input logic [WIDTH-1:0] er, input logic ec, input logic eo, input logic ei,
                          input int elat);
        int lat;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        issue(va, vb, op);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".result"}, 64'(result), 64'(er));
        check({tag, ".carry"}, 64'(carry), 64'(ec));
        check({tag, ".overflow"}, 64'(overflow), 64'(eo));
        check({tag, ".illegal"}, 64'(illegal), 64'(ei));
        check({tag, ".zero"}, 64'(zero), 64'(er == '0));
        check({tag, ".negative"}, 64'(negative), 64'(er[WIDTH-1]));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".drain"}, 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.result", 64'(result), 64'd0);
        check("rst.flags", 64'({carry, overflow, illegal, negative}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        //        tag        a              b              op     result         c     o     ill   lat
        run_op("add_wrap", 32'hFFFF_FFFF, 32'h1,         4'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1);
        run_op("add_ovf",  32'h7FFF_FFFF, 32'h1,         4'd0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1);
        run_op("sub_brw",  32'd5,         32'd10,        4'd1, 32'hFFFF_FFFB, 1'b1, 1'b0, 1'b0, 1);
        run_op("sub_ovf",  32'h8000_0000, 32'h1,         4'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
        run_op("and",      32'hFF00_FF00, 32'h0F0F_0F0F, 4'd2, 32'h0F00_0F00, 1'b0, 1'b0, 1'b0, 1);
        run_op("or",       32'hFF00_FF00, 32'h0F0F_0F0F, 4'd3, 32'hFF0F_FF0F, 1'b0, 1'b0, 1'b0, 1);
        run_op("xor",      32'hFF00_FF00, 32'h0F0F_0F0F, 4'd4, 32'hF00F_F00F, 1'b0, 1'b0, 1'b0, 1);
        run_op("not",      32'h0,         32'h1234,      4'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1);
        run_op("sll",      32'h1,         32'h21,        4'd6, 32'h2,         1'b0, 1'b0, 1'b0, 1);
        run_op("srl",      32'h8000_0010, 32'h24,        4'd7, 32'h0800_0001, 1'b0, 1'b0, 1'b0, 1);
        run_op("sra",      32'h8000_0010, 32'h24,        4'd8, 32'hF800_0001, 1'b0, 1'b0, 1'b0, 1);
        run_op("mul_hi",   32'h0001_0000, 32'h0002_0000, 4'd9, 32'h0,         1'b1, 1'b0, 1'b0, 33);
        run_op("mul_lo",   32'd12,        32'd11,        4'd9, 32'd132,       1'b0, 1'b0, 1'b0, 33);
        run_op("illegal",  32'h55,        32'h66,        4'hC, 32'h0,         1'b0, 1'b0, 1'b1, 1);

        // Backpressure: result held, in_ready low, a request presented meanwhile is ignored.
        issue(32'd10, 32'd5, 4'd0);
        for (int unsigned i = 0; i < 5; i++) begin
            if (i == 2) begin
                a = 32'd1; b = 32'd1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check("bp.result", 64'(result), 64'd15);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release_valid", 64'(out_valid), 64'd0);
        check("bp.release_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // Reset mid-multiply discards the operation.
        issue(32'd7, 32'd9, 4'd9);
        repeat (9) @(posedge clk);
        #1;
        check("mrst.busy", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst.out_valid", 64'(out_valid), 64'd0);
        check("mrst.in_ready", 64'(in_ready), 64'd1);
        check("mrst.result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("mrst.no_late_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
